multdiv_ctrl: RTL and testbench

Sequencer for the iterative multiplier and divider datapaths in the MultDiv unit. Accepts one-cycle `ctrl_MULT` / `ctrl_DIV` start pulses and drives a load strobe and per-iteration step strobes. Replaces the free-running divide step counter with an explicit FSM-owned iteration count. Produces a one-cycle `result_rdy` pulse with exception flagging for divide-by-zero and multiply overflow.

---
 rtl/multdiv_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
//   Sequencer for the iterative multiply / divide datapaths. A one-cycle start
//   pulse moves the FSM through LOAD (operand latch), RUN (one step strobe per
//   iteration, counted by an FSM-owned counter) and DONE (one-cycle result_rdy
//   with exception flag).
//
//   Optional feature macro: MULTDIV_ABORT_EN
//     defined   : a start pulse in LOAD or RUN aborts the current operation
//                 (no result_rdy) and restarts in LOAD with the new op.
//     undefined : start pulses in LOAD or RUN are ignored.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   ctrl_MULT     start multiply (pulse); wins over ctrl_DIV when both high
//   ctrl_DIV      start divide (pulse)
//   divisor_zero  divide datapath: latched divisor is zero (sampled in LOAD)
//   mult_ovf      multiply datapath: product overflow (sampled in DONE)
//   load          datapath latches operands
//   step          datapath performs one iteration
//   op_div        0 = multiply, 1 = divide; held for the whole operation
//   step_idx      current iteration index while step is high, else 0
//   busy          high in LOAD, RUN and DONE
//   result_rdy    one-cycle pulse, datapath result valid
//   exception     divide-by-zero / multiply overflow, only with result_rdy
// -----------------------------------------------------------------------------
module multdiv_ctrl #(
  parameter int MULT_STEPS = 32,
  parameter int DIV_STEPS  = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  input  logic             mult_ovf,
  output logic             load,
  output logic             step,
  output logic             op_div,
  output logic [CNT_W-1:0] step_idx,
  output logic             busy,
  output logic             result_rdy,
  output logic             exception
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

`ifdef MULTDIV_ABORT_EN
  localparam logic ABORT_EN = 1'b1;
`else
  localparam logic ABORT_EN = 1'b0;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_op_div;
  logic             w_op_div_nxt;
  logic             r_dz;        // latched divide-by-zero flag
  logic             w_dz_nxt;
  logic             w_start;
  logic             w_abort;
  logic [CNT_W-1:0] w_last;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_abort = ABORT_EN & w_start;
  assign w_last  = r_op_div ? DIV_LAST : MULT_LAST;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath-side registers: iteration counter, op select, div-zero latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_op_div <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_op_div <= w_op_div_nxt;
      r_dz     <= w_dz_nxt;
    end
  end

  // Next-state logic. A new start always selects multiply over divide, and
  // entering LOAD always clears the counter and the div-zero latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_op_div_nxt = r_op_div;
    w_dz_nxt     = r_dz;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = {CNT_W{1'b0}};
        w_dz_nxt  = 1'b0;
        if (w_start) begin
          w_state_nxt  = S_LOAD;
          w_op_div_nxt = ~ctrl_MULT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_cnt_nxt = {CNT_W{1'b0}};
        if (w_abort) begin
          w_state_nxt  = S_LOAD;
          w_op_div_nxt = ~ctrl_MULT;
          w_dz_nxt     = 1'b0;
        end else if (r_op_div && divisor_zero) begin
          // Divide by zero skips the iterations entirely.
          w_state_nxt = S_DONE;
          w_dz_nxt    = 1'b1;
        end else begin
          w_state_nxt = S_RUN;
          w_dz_nxt    = 1'b0;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt  = S_LOAD;
          w_op_div_nxt = ~ctrl_MULT;
          w_cnt_nxt    = {CNT_W{1'b0}};
          w_dz_nxt     = 1'b0;
        end else if (r_cnt == w_last) begin
          // Counter holds at the terminal value rather than wrapping.
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        if (w_start) begin
          w_state_nxt  = S_LOAD;
          w_op_div_nxt = ~ctrl_MULT;
          w_cnt_nxt    = {CNT_W{1'b0}};
          w_dz_nxt     = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_cnt_nxt    = {CNT_W{1'b0}};
        w_op_div_nxt = 1'b0;
        w_dz_nxt     = 1'b0;
      end
    endcase
  end

  // Outputs are pure decodes of registered state; mult_ovf is the only input
  // reaching an output, and only while in DONE.
  assign load       = (r_state == S_LOAD);
  assign step       = (r_state == S_RUN);
  assign result_rdy = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign op_div     = busy & r_op_div;
  assign step_idx   = step ? r_cnt : {CNT_W{1'b0}};
  assign exception  = result_rdy & (r_op_div ? r_dz : mult_ovf);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_ctrl
//   Scoreboard bench for multdiv_ctrl. Each start pulse pushes the expected
//   result (completion cycle, exception, op select, step count); a negedge
//   monitor pops and compares on every result_rdy and checks strobe rules.
// -----------------------------------------------------------------------------
module tb_multdiv_ctrl;

  localparam int MS = 32;
  localparam int DS = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ctrl_MULT = 1'b0;
  logic          ctrl_DIV = 1'b0;
  logic          divisor_zero = 1'b0;
  logic          mult_ovf = 1'b0;
  logic          load, step, op_div, busy, result_rdy, exception;
  logic [CW-1:0] step_idx;

  typedef struct {
    int   cyc;
    logic exc;
    logic opd;
    int   nsteps;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   st_cnt = 0;

  multdiv_ctrl #(.MULT_STEPS(MS), .DIV_STEPS(DS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .divisor_zero(divisor_zero), .mult_ovf(mult_ovf), .load(load),
    .step(step), .op_div(op_div), .step_idx(step_idx), .busy(busy),
    .result_rdy(result_rdy), .exception(exception)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected completion: start sampled at edge cyc+1, LOAD, N RUN cycles, DONE.
  task automatic push_exp(input logic m, input logic dz, input logic ovf);
    exp_t e;
    int   n;
    n = m ? MS : (dz ? 0 : DS);
    e.cyc = cyc + n + 2;
    e.exc = m ? ovf : dz;
    e.opd = ~m;
    e.nsteps = n;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    chk_eq("drain", sb_q.size(), 0);
  endtask

  task automatic run_op(input logic m, input logic d, input logic ovf, input logic dz);
    mult_ovf = ovf;
    divisor_zero = dz;
    push_exp(m, dz, ovf);
    ctrl_MULT = m;
    ctrl_DIV = d;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    wait_drain();
    chk_eq("busy_after", busy, 0);
  endtask

  // Monitor: strobe exclusivity, step index sequence, scoreboard pop.
  always @(negedge clk) begin
    if (reset) begin
      chk_eq("excl", {29'd0, load & step, result_rdy & (load | step), exception & ~result_rdy}, 0);
      if (load) st_cnt = 0;
      if (step) begin
        chk_eq("step_idx", step_idx, st_cnt);
        st_cnt = st_cnt + 1;
      end
      if (result_rdy) begin
        if (sb_q.size() == 0) begin
          chk_eq("spurious_rdy", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk_eq("rdy_cyc", cyc, e.cyc);
          chk_eq("exc", exception, e.exc);
          chk_eq("op_div", op_div, e.opd);
          chk_eq("nsteps", st_cnt, e.nsteps);
        end
      end
    end
  end

  initial begin
    int k;
    // Reset state
    #2;
    chk_eq("rst_outs", {24'd0, load, step, op_div, busy, result_rdy, exception}, 0);
    chk_eq("rst_idx", step_idx, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Plain multiply, multiply with overflow, divide, divide by zero
    run_op(1'b1, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 1'b0, 1'b1);
    // Divisor-zero must not matter for a multiply
    run_op(1'b1, 1'b0, 1'b0, 1'b1);
    // Simultaneous starts: multiply wins
    run_op(1'b1, 1'b1, 1'b0, 1'b0);

    // ctrl_DIV ten cycles into a multiply
    mult_ovf = 1'b0;
    divisor_zero = 1'b0;
    k = cyc;
`ifndef MULTDIV_ABORT_EN
    push_exp(1'b1, 1'b0, 1'b0);
`endif
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    repeat (9) tick();
    chk_eq("mid_cyc", cyc - k, 10);
`ifdef MULTDIV_ABORT_EN
    push_exp(1'b0, 1'b0, 1'b0);
`endif
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
`ifdef MULTDIV_ABORT_EN
    chk_eq("abort_load", {load, op_div}, 2'b11);
`else
    chk_eq("noabort_run", {load, step, op_div}, 3'b010);
`endif
    wait_drain();
    chk_eq("mid_busy", busy, 0);

    // Asynchronous reset mid-RUN
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    repeat (5) tick();
    chk_eq("pre_rst_step", step, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_eq("async_rst_outs", {24'd0, load, step, op_div, busy, result_rdy, exception}, 0);
    chk_eq("async_rst_idx", step_idx, 0);
    tick(); tick();
    reset = 1'b1;
    repeat (40) tick();
    chk_eq("post_rst_busy", busy, 0);

    // Back-to-back: divide started in the DONE cycle of a multiply
    push_exp(1'b1, 1'b0, 1'b0);
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    repeat (MS + 1) tick();
    chk_eq("b2b_done", result_rdy, 1);
    push_exp(1'b0, 1'b0, 1'b0);
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    chk_eq("b2b_load", {load, op_div}, 2'b11);
    wait_drain();
    chk_eq("b2b_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
